// File: rtl/i2c_receptor_if.sv
// rtl/i2c_receptor_if.sv - serial I2C loop between transaction generator (master) and target (slave)
interface i2c_receptor_if;
  logic SCL;
  logic SDA_OUT;
  logic SDA_OE;
  logic SDA_IN;

  modport master (output SCL, output SDA_OUT, output SDA_OE, input SDA_IN);
  modport slave (input SCL, input SDA_OUT, input SDA_OE, output SDA_IN);
endinterface

// File: rtl/i2c_receptor.sv
// rtl/i2c_receptor.sv - I2C target: start/stop decode, address match + ACK, 16-bit write capture, read serialiser
module i2c_receptor #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  i2c_receptor_if.slave     bus,
  input  logic [ADDR_W-1:0] I2C_ADDR,
  input  logic [WORD_W-1:0] RD_DATA,
  output logic [WORD_W-1:0] WR_DATA,
  output logic              WR_STB,
  output logic              RD_STB,
  output logic              BUSY
);

  localparam int CNT_W = $clog2(((WORD_W > ADDR_W) ? WORD_W : ADDR_W) + 2);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] WORD_FULL = CNT_W'(WORD_W);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    WRITE,
    ACK_WRITE,
    READ,
    WAIT_MACK
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] addr_sr;
  logic [WORD_W-2:0] wr_sr;
  logic [WORD_W-1:0] rd_sr;
  logic              rnw;
  logic              ph;
  logic              scl_q;
  logic              sda_q;

  logic rise;
  logic fall;
  logic start;
  logic stop;
  logic sda_bit;

  assign rise  = bus.SCL & ~scl_q;
  assign fall  = ~bus.SCL & scl_q;
  assign start = bus.SCL & scl_q & sda_q & ~bus.SDA_OUT;
  assign stop  = bus.SCL & scl_q & ~sda_q & bus.SDA_OUT;
  // An undriven line reads as the pull-up level.
  assign sda_bit = bus.SDA_OE ? bus.SDA_OUT : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      addr_sr    <= '0;
      wr_sr      <= '0;
      rd_sr      <= '0;
      rnw        <= 1'b0;
      ph         <= 1'b0;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      bus.SDA_IN <= 1'b1;
      WR_DATA    <= '0;
      WR_STB     <= 1'b0;
      RD_STB     <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      scl_q  <= bus.SCL;
      sda_q  <= bus.SDA_OUT;
      WR_STB <= 1'b0;
      RD_STB <= 1'b0;

      if (start) begin
        state      <= ADDR;
        bit_cnt    <= '0;
        ph         <= 1'b0;
        BUSY       <= 1'b1;
        bus.SDA_IN <= 1'b1;
      end else if (stop) begin
        state      <= IDLE;
        ph         <= 1'b0;
        BUSY       <= 1'b0;
        bus.SDA_IN <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
          end

          // addr_sr still holds the 7 address bits when the RNW bit arrives
          ADDR: begin
            if (rise) begin
              addr_sr <= {addr_sr[ADDR_W-2:0], bus.SDA_OUT};
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == ADDR_LAST) begin
                rnw <= bus.SDA_OUT;
                if (addr_sr == I2C_ADDR) begin
                  state <= ACK_ADDR;
                  ph    <= 1'b0;
                end else begin
                  state <= IDLE;
                  BUSY  <= 1'b0;
                end
              end
            end
          end

          ACK_ADDR: begin
            if (fall) begin
              if (!ph) begin
                bus.SDA_IN <= 1'b0;
                ph         <= 1'b1;
              end else begin
                ph      <= 1'b0;
                bit_cnt <= '0;
                if (rnw) begin
                  rd_sr      <= {RD_DATA[WORD_W-2:0], 1'b0};
                  RD_STB     <= 1'b1;
                  bus.SDA_IN <= RD_DATA[WORD_W-1];
                  state      <= READ;
                end else begin
                  bus.SDA_IN <= 1'b1;
                  state      <= WRITE;
                end
              end
            end
          end

          WRITE: begin
            if (rise) begin
              wr_sr   <= {wr_sr[WORD_W-3:0], sda_bit};
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == WORD_LAST) begin
                WR_DATA <= {wr_sr, sda_bit};
                WR_STB  <= 1'b1;
                ph      <= 1'b0;
                state   <= ACK_WRITE;
              end
            end
          end

          ACK_WRITE: begin
            if (fall) begin
              if (!ph) begin
                bus.SDA_IN <= 1'b0;
                ph         <= 1'b1;
              end else begin
                bus.SDA_IN <= 1'b1;
                ph         <= 1'b0;
                bit_cnt    <= '0;
                state      <= WRITE;
              end
            end
          end

          // rd_sr is kept pre-shifted: its MSB is always the next bit to drive
          READ: begin
            if (rise) begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end else if (fall) begin
              if (bit_cnt < WORD_FULL) begin
                bus.SDA_IN <= rd_sr[WORD_W-1];
                rd_sr      <= {rd_sr[WORD_W-2:0], 1'b0};
              end else begin
                bus.SDA_IN <= 1'b1;
                ph         <= 1'b0;
                state      <= WAIT_MACK;
              end
            end
          end

          WAIT_MACK: begin
            if (rise && !ph) begin
              if (sda_bit) begin
                state <= IDLE;
                BUSY  <= 1'b0;
              end else begin
                ph <= 1'b1;
              end
            end else if (fall && ph) begin
              rd_sr      <= {RD_DATA[WORD_W-2:0], 1'b0};
              RD_STB     <= 1'b1;
              bus.SDA_IN <= RD_DATA[WORD_W-1];
              bit_cnt    <= '0;
              ph         <= 1'b0;
              state      <= READ;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_receptor.sv
// tb/tb_i2c_receptor.sv - bench for i2c_receptor: master model, transaction-level reference, scoreboard monitor
module tb_i2c_receptor;

  logic        clk;
  logic        rst;
  logic [6:0]  i2c_addr;
  logic [15:0] rd_data;
  logic [15:0] wr_data;
  logic        wr_stb;
  logic        rd_stb;
  logic        busy;

  i2c_receptor_if bus_if();

  i2c_receptor #(.WORD_W(16), .ADDR_W(7)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .I2C_ADDR (i2c_addr),
    .RD_DATA  (rd_data),
    .WR_DATA  (wr_data),
    .WR_STB   (wr_stb),
    .RD_STB   (rd_stb),
    .BUSY     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        exp_sda[$];
  logic [15:0] exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [15:0] last_wr;
  logic [15:0] wbuf[4];
  logic        tgt_slot = 1'b0;
  logic        scl_prev = 1'b1;
  logic        sda_prev = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe or owns an SDA slot.
  always @(negedge clk) begin
    if (wr_stb) begin
      if (exp_wr.size() == 0) check("wr_stb_unexpected", 32'(wr_data), 32'hFFFF_FFFF);
      else check("wr_data", 32'(wr_data), 32'(exp_wr.pop_front()));
    end
    if (rd_stb) begin
      if (exp_rd.size() == 0) check("rd_stb_unexpected", 32'(rd_data), 32'hFFFF_FFFF);
      else check("rd_stb_word", 32'(rd_data), 32'(exp_rd.pop_front()));
    end
    if (wr_stb || rd_stb) check("strobe_overlap", 32'(wr_stb & rd_stb), 32'd0);
    if (bus_if.SCL && !scl_prev && tgt_slot) begin
      if (exp_sda.size() == 0) check("sda_slot_unexpected", 32'(bus_if.SDA_IN), 32'hFFFF_FFFF);
      else check("sda_in_slot", 32'(bus_if.SDA_IN), 32'(exp_sda.pop_front()));
    end
    if (bus_if.SCL && scl_prev && busy) check("sda_in_stable_scl_high", 32'(bus_if.SDA_IN), 32'(sda_prev));
    scl_prev <= bus_if.SCL;
    sda_prev <= bus_if.SDA_IN;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One SCL period: low half (data set up), high half (sampled).
  task automatic clk_bit(input logic drv, input logic val, input logic tgt, input logic expv);
    bus_if.SCL = 1'b0;
    tick();
    bus_if.SDA_OE  = drv;
    bus_if.SDA_OUT = drv ? val : 1'b1;
    tgt_slot = tgt;
    if (tgt) exp_sda.push_back(expv);
    tick();
    bus_if.SCL = 1'b1;
    tick();
    tick();
  endtask

  task automatic do_start();
    bus_if.SCL = 1'b0;
    tick();
    tgt_slot = 1'b0;
    bus_if.SDA_OE  = 1'b1;
    bus_if.SDA_OUT = 1'b1;
    tick();
    bus_if.SCL = 1'b1;
    tick();
    tick();
    bus_if.SDA_OUT = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_stop();
    bus_if.SCL = 1'b0;
    tick();
    tgt_slot = 1'b0;
    bus_if.SDA_OE  = 1'b1;
    bus_if.SDA_OUT = 1'b0;
    tick();
    bus_if.SCL = 1'b1;
    tick();
    tick();
    bus_if.SDA_OUT = 1'b1;
    tick();
    tick();
  endtask

  task automatic send_addr(input logic [6:0] a, input logic rnw, output logic match);
    logic [7:0] byte_v;
    match  = (a == i2c_addr);
    byte_v = {a, rnw};
    do_start();
    for (int i = 7; i >= 0; i--) clk_bit(1'b1, byte_v[i], 1'b0, 1'b0);
    check("busy_after_addr", 32'(busy), 32'(match));
    clk_bit(1'b0, 1'b1, 1'b1, !match);
  endtask

  // Reference transaction: n words from wbuf; reads ACK every word but the last.
  task automatic xfer(input logic [6:0] a, input logic rnw, input int n, input logic stop_after);
    logic match;
    if (rnw) rd_data = wbuf[0];
    send_addr(a, rnw, match);
    if (!match) begin
      do_stop();
      check("busy_after_mismatch", 32'(busy), 32'd0);
      return;
    end
    for (int k = 0; k < n; k++) begin
      if (rnw) begin
        exp_rd.push_back(wbuf[k]);
        for (int b = 15; b >= 0; b--) clk_bit(1'b0, 1'b1, 1'b1, wbuf[k][b]);
        if (k < n - 1) begin
          rd_data = wbuf[k+1];
          clk_bit(1'b1, 1'b0, 1'b0, 1'b0);
        end else begin
          clk_bit(1'b1, 1'b1, 1'b0, 1'b0);
          check("busy_after_nack", 32'(busy), 32'd0);
        end
      end else begin
        exp_wr.push_back(wbuf[k]);
        last_wr = wbuf[k];
        for (int b = 15; b >= 0; b--) clk_bit(1'b1, wbuf[k][b], 1'b0, 1'b0);
        clk_bit(1'b0, 1'b1, 1'b1, 1'b0);
      end
    end
    if (!rnw) check("wr_data_hold", 32'(wr_data), 32'(last_wr));
    if (stop_after) begin
      do_stop();
      check("busy_after_stop", 32'(busy), 32'd0);
      check("sda_released_after_stop", 32'(bus_if.SDA_IN), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic match;
    rst = 1'b1;
    i2c_addr = 7'h50;
    rd_data = 16'h0000;
    bus_if.SCL = 1'b1;
    bus_if.SDA_OUT = 1'b1;
    bus_if.SDA_OE = 1'b1;
    last_wr = 16'h0000;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_sda_in", 32'(bus_if.SDA_IN), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_wr_data", 32'(wr_data), 32'd0);
    check("reset_strobes", 32'({wr_stb, rd_stb}), 32'd0);

    wbuf[0] = 16'hA5C3;
    xfer(7'h50, 1'b0, 1, 1'b1);
    wbuf[0] = 16'h1234;
    xfer(7'h50, 1'b1, 1, 1'b1);
    wbuf[0] = 16'hDEAD;
    xfer(7'h51, 1'b0, 1, 1'b1);
    check("wr_data_after_mismatch", 32'(wr_data), 32'(last_wr));

    wbuf[0] = 16'h00FF;
    xfer(7'h50, 1'b0, 1, 1'b0);
    wbuf[0] = 16'hBEEF;
    xfer(7'h50, 1'b1, 1, 1'b1);

    // Stop after 9 write bits: partial word must be dropped.
    send_addr(7'h50, 1'b0, match);
    for (int b = 0; b < 9; b++) clk_bit(1'b1, b[0], 1'b0, 1'b0);
    do_stop();
    check("partial_wr_data", 32'(wr_data), 32'(last_wr));
    check("partial_busy", 32'(busy), 32'd0);
    check("partial_sda_in", 32'(bus_if.SDA_IN), 32'd1);

    // Reset pulse during read bit 5.
    rd_data = 16'h5A5A;
    exp_rd.push_back(16'h5A5A);
    send_addr(7'h50, 1'b1, match);
    for (int b = 15; b > 10; b--) clk_bit(1'b0, 1'b1, 1'b1, rd_data[b]);
    bus_if.SCL = 1'b0;
    tick();
    tgt_slot = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_wr = 16'h0000;
    check("rst_mid_sda_in", 32'(bus_if.SDA_IN), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_wr_data", 32'(wr_data), 32'd0);
    bus_if.SCL = 1'b1;
    tick();
    tick();
    wbuf[0] = 16'h0F0F;
    xfer(7'h50, 1'b0, 1, 1'b1);

    for (int t = 0; t < 30; t++) begin
      logic [6:0] a;
      logic       rnw;
      int         n;
      a   = ($urandom_range(0, 3) != 0) ? 7'h50 : 7'($urandom);
      rnw = 1'($urandom);
      n   = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) wbuf[i] = 16'($urandom);
      xfer(a, rnw, n, ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
    end
    do_stop();
    repeat (4) tick();

    check("exp_sda_drained", 32'(exp_sda.size()), 32'd0);
    check("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
    check("exp_rd_drained", 32'(exp_rd.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
